ssd_scan_driver: RTL and testbench
==================================

SSD_SCAN_DRIVER -- requirements
Module: ssd_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits; legal range 1-8.
REQ-002 Parameter REFRESH_DIV, default 100000: clock cycles each digit is displayed; minimum 2.
REQ-003 Parameter LZ_BLANK, default 1: 1 enables leading-zero blanking, 0 disables it.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 bcd_in  input  4*NUM_DIGITS  BCD value; nibble k is digit k; digit 0 is least significant.
REQ-007 dp_in  input  NUM_DIGITS  decimal-point request per digit, active-high.
REQ-008 load  input  1  single-cycle strobe that captures bcd_in and dp_in.
REQ-009 blank  input  1  active-high; forces the display dark.
REQ-010 seg  output  7  segments {a,b,c,d,e,f,g}, seg[6]=a, active-low.
REQ-011 dp  output  1  decimal point, active-low.
REQ-012 an  output  NUM_DIGITS  digit anodes, active-low, one-hot-low while scanning.
REQ-013 frame_done  output  1  one-cycle pulse at the end of each full scan.

Function
REQ-014 The prescaler shall count 0..REFRESH_DIV-1 and wrap; the tick is prescaler==REFRESH_DIV-1.
REQ-015 On tick, digit index shall advance by one and wrap from NUM_DIGITS-1 to 0; the index shall hold otherwise.
REQ-016 The boundary event is tick with index==NUM_DIGITS-1; frame_done shall be 1 in the cycle after the boundary edge only.
REQ-017 A load shall write bcd_in/dp_in to a pending buffer and set a pending flag; the displayed (shadow) register shall not change on load alone.
REQ-018 On a boundary with the pending flag set, the block shall copy pending to shadow and clear the flag.
REQ-019 Load coincident with a boundary: bcd_in/dp_in go directly to shadow on that edge and the flag is cleared.
REQ-020 Back-to-back loads within one frame: the last load wins.
REQ-021 seg, dp, and an shall be registered, reflecting the index and shadow from the previous cycle (latency 1 cycle).
REQ-022 Decode 0-9 (active-low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-023 Shadow nibble codes 10-15 shall drive seg=1111111, with dp still honoured.
REQ-024 With LZ_BLANK=1, digit k>0 shall be dark (seg=1111111, dp=1) when it and every more-significant digit are 0; digit 0 is never zero-blanked.
REQ-025 A zero-blanked digit with dp_in set shall still show its dp (dp=0).
REQ-026 an shall drive bit index low and all other bits high.
REQ-027 While blank=1, registered outputs shall be an all 1s, seg=1111111, and dp=1; the prescaler, index, load, and frame_done shall continue unaffected.
REQ-028 With NUM_DIGITS=1, every tick is a boundary.

Reset
REQ-029 While rst=1: prescaler=0, index=0, shadow=0, pending=0, flag=0, seg=1111111, dp=1, an all 1s, frame_done=0.
REQ-030 On the first edge after rst falls: an=...1110 and seg=0000001 (digit 0 shows "0"); higher digits are zero-blanked per REQ-024.
REQ-031 rst asserted mid-frame or mid-pending shall discard the pending data; the pending data shall never reach shadow.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, LZ_BLANK=1)
REQ-032 Reset release, no load -> an cycles 1110,1101,1011,0111 every 4 clocks; seg=0000001 only on digit 0, dark elsewhere; frame_done pulses every 16 clocks.
REQ-033 load bcd_in=0x1234 mid-frame -> display unchanged until the next boundary; then digit3..0 seg = 1001111, 0010010, 0000110, 1001100.
REQ-034 Shadow 0x0050, dp_in=0100 -> digit3 dark; digit2 dark with dp=0; digit1 seg=0100100; digit0 seg=0000001.
REQ-035 bcd_in=0x9A0F loaded -> digits 2 and 0 show 1111111; digit 3 shows 0000100; digit 1 shows 0000001 (not leading).
REQ-036 Load asserted on the boundary cycle -> new value is visible on the very next digit-0 slot; load of 0x1111 then 0x2222 within one frame -> 0x2222 is displayed.
REQ-037 blank=1 for 10 cycles mid-frame -> an all 1s after 1 cycle; on release, scan resumes at the index it would have reached; frame_done timing unchanged. Async rst pulse between clock edges -> outputs dark immediately and pending data is lost.

Source files
------------

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver
//   Time-multiplexed seven-segment display driver. A prescaler divides the
//   clock so that each digit is lit for REFRESH_DIV cycles. Digits are lit in
//   order 0..NUM_DIGITS-1, and a pulse marks the end of each full scan. New
//   values are captured into a pending buffer and only become visible at a
//   frame boundary, so a frame never shows a mix of old and new digits.
//
// Parameters
//   NUM_DIGITS  : number of multiplexed digits (1..8)
//   REFRESH_DIV : clock cycles each digit is lit (>= 2)
//   LZ_BLANK    : 1 = blank leading zeros on digits above digit 0
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   bcd_in     : BCD digits, nibble k = digit k, digit 0 least significant
//   dp_in      : decimal-point request per digit, active-high
//   load       : one-cycle strobe capturing bcd_in / dp_in
//   blank      : active-high, forces the display dark (scan keeps running)
//   seg        : segments {a,b,c,d,e,f,g}, seg[6] = a, active-low, registered
//   dp         : decimal point, active-low, registered
//   an         : digit anodes, active-low one-hot, registered
//   frame_done : one-cycle pulse after the last digit slot of a scan
module ssd_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int LZ_BLANK    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  // Active-low segment pattern for a BCD nibble; codes 10-15 are dark.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [PW-1:0]           presc_r;
  logic [IW-1:0]           idx_r;
  logic [4*NUM_DIGITS-1:0] shadow_bcd_r;
  logic [NUM_DIGITS-1:0]   shadow_dp_r;
  logic [4*NUM_DIGITS-1:0] pend_bcd_r;
  logic [NUM_DIGITS-1:0]   pend_dp_r;
  logic                    pend_flag_r;

  logic                    tick_s;
  logic                    boundary_s;
  logic                    lz_run_s;
  logic [NUM_DIGITS-1:0]   lz_s;
  logic [3:0]              cur_nib_s;
  logic                    cur_dp_s;
  logic                    cur_lz_s;
  logic [NUM_DIGITS-1:0]   an_sel_s;
  logic [6:0]              seg_next_s;
  logic                    dp_next_s;
  logic [NUM_DIGITS-1:0]   an_next_s;

  assign tick_s     = (presc_r == PRESC_LAST);
  assign boundary_s = tick_s & (idx_r == IDX_LAST);

  // Prescaler and digit index: the index steps once per prescaler wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r <= '0;
      idx_r   <= '0;
    end else begin
      if (tick_s) begin
        presc_r <= '0;
        idx_r   <= (idx_r == IDX_LAST) ? '0 : idx_r + IW'(1);
      end else begin
        presc_r <= presc_r + PW'(1);
      end
    end
  end

  // Pending / shadow buffers: new data reaches the display only at a frame
  // boundary. A load landing exactly on the boundary bypasses the pending
  // buffer so it is not delayed by a whole frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_bcd_r <= '0;
      shadow_dp_r  <= '0;
      pend_bcd_r   <= '0;
      pend_dp_r    <= '0;
      pend_flag_r  <= 1'b0;
    end else begin
      if (load && boundary_s) begin
        shadow_bcd_r <= bcd_in;
        shadow_dp_r  <= dp_in;
        pend_flag_r  <= 1'b0;
      end else if (load) begin
        pend_bcd_r   <= bcd_in;
        pend_dp_r    <= dp_in;
        pend_flag_r  <= 1'b1;
      end else if (boundary_s && pend_flag_r) begin
        shadow_bcd_r <= pend_bcd_r;
        shadow_dp_r  <= pend_dp_r;
        pend_flag_r  <= 1'b0;
      end
    end
  end

  // Leading-zero mask: digit k is blanked when it and every digit above it
  // are zero. Digit 0 is never blanked so a zero value still shows "0".
  always_comb begin
    lz_run_s = 1'b1;
    lz_s     = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      lz_run_s = lz_run_s & (shadow_bcd_r[4*k +: 4] == 4'd0);
      lz_s[k]  = lz_run_s & (k != 0) & (LZ_BLANK != 0);
    end
  end

  // Select the currently scanned digit's nibble, dp and blank flag.
  always_comb begin
    cur_nib_s = 4'd0;
    cur_dp_s  = 1'b0;
    cur_lz_s  = 1'b0;
    an_sel_s  = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_r == IW'(k)) begin
        cur_nib_s   = shadow_bcd_r[4*k +: 4];
        cur_dp_s    = shadow_dp_r[k];
        cur_lz_s    = lz_s[k];
        an_sel_s[k] = 1'b0;
      end else begin
        an_sel_s[k] = 1'b1;
      end
    end
  end

  // Next output values; a zero-blanked digit still shows its decimal point.
  always_comb begin
    seg_next_s = 7'b1111111;
    dp_next_s  = 1'b1;
    an_next_s  = '1;
    if (blank) begin
      seg_next_s = 7'b1111111;
      dp_next_s  = 1'b1;
      an_next_s  = '1;
    end else begin
      an_next_s = an_sel_s;
      dp_next_s = ~cur_dp_s;
      if (cur_lz_s) begin
        seg_next_s = 7'b1111111;
      end else begin
        seg_next_s = bcd_to_seg(cur_nib_s);
      end
    end
  end

  // Output registers: one cycle behind the index/shadow state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= 7'b1111111;
      dp         <= 1'b1;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_next_s;
      dp         <= dp_next_s;
      an         <= an_next_s;
      frame_done <= boundary_s;
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Testbench for ssd_scan_driver (NUM_DIGITS=4, REFRESH_DIV=4, LZ_BLANK=1).
// Stimulus pushes hand-computed display states and frame_done cycle numbers
// into queues; a monitor pops and compares each time the display changes
// and each time frame_done is seen.
module tb_ssd_scan_driver;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } ev_t;

  localparam ev_t DARK = {4'b1111, 7'b1111111, 1'b1};

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S6 = 7'b0100000;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] SX = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bcd_in = 16'h0000;
  logic [3:0]  dp_in = 4'b0000;
  logic        load = 1'b0;
  logic        blank = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  ev_t  ev_q[$];
  int   fd_q[$];

  ssd_scan_driver #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(4),
    .LZ_BLANK   (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bcd_in    (bcd_in),
    .dp_in     (dp_in),
    .load      (load),
    .blank     (blank),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Edge count since the last reset release; cyc == i right after edge i.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic ev_push(input logic [3:0] a, input logic [6:0] s, input logic d);
    ev_q.push_back({a, s, d});
  endtask

  // One full scan: digit 0..3 segments and dp outputs.
  task automatic push_frame(input logic [6:0] s0, input logic d0,
                            input logic [6:0] s1, input logic d1,
                            input logic [6:0] s2, input logic d2,
                            input logic [6:0] s3, input logic d3);
    ev_push(4'b1110, s0, d0);
    ev_push(4'b1101, s1, d1);
    ev_push(4'b1011, s2, d2);
    ev_push(4'b0111, s3, d3);
  endtask

  // Return 1 time unit after edge n (inputs set here are sampled at edge n+1).
  task automatic at_cycle(input int n);
    int guard;
    guard = 0;
    forever begin
      @(posedge clk);
      #1;
      if (cyc == n) break;
      guard++;
      if (guard > 300) begin
        total++;
        bad++;
        $display("FAIL at_cycle_timeout: got cyc=%0d want cyc=%0d", cyc, n);
        break;
      end
    end
  endtask

  task automatic do_load(input int n, input logic [15:0] v, input logic [3:0] d);
    at_cycle(n);
    bcd_in = v;
    dp_in  = d;
    load   = 1'b1;
    at_cycle(n + 1);
    load   = 1'b0;
  endtask

  ev_t cur_m;
  ev_t last_m;
  ev_t exp_m;
  int  exp_fd;

  // Monitor: compares on every display change and every frame_done pulse.
  always @(negedge clk) begin
    cur_m = {an, seg, dp};
    if (rst) begin
      total++;
      if (cur_m !== DARK || frame_done !== 1'b0) begin
        bad++;
        $display("FAIL reset_state: got an=%b seg=%b dp=%b fd=%b want an=1111 seg=1111111 dp=1 fd=0",
                 an, seg, dp, frame_done);
      end
      last_m = cur_m;
    end else begin
      if (cur_m !== last_m) begin
        total++;
        if (ev_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event: got an=%b seg=%b dp=%b at cyc=%0d want no change",
                   an, seg, dp, cyc);
        end else begin
          exp_m = ev_q.pop_front();
          if (cur_m !== exp_m) begin
            bad++;
            $display("FAIL display_event: got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b at cyc=%0d",
                     an, seg, dp, exp_m.an, exp_m.seg, exp_m.dp, cyc);
          end
        end
        last_m = cur_m;
      end
      if (frame_done === 1'b1) begin
        total++;
        if (fd_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_frame_done: got pulse at cyc=%0d want none", cyc);
        end else begin
          exp_fd = fd_q.pop_front();
          if (cyc != exp_fd) begin
            bad++;
            $display("FAIL frame_done_time: got cyc=%0d want cyc=%0d", cyc, exp_fd);
          end
        end
      end
    end
  end

  initial begin
    // Frames 0 and 1: reset contents, only digit 0 lit. 0x1234 loaded
    // mid-frame 1 must not appear before the boundary.
    push_frame(S0, 1'b1, SX, 1'b1, SX, 1'b1, SX, 1'b1);
    push_frame(S0, 1'b1, SX, 1'b1, SX, 1'b1, SX, 1'b1);
    fd_q.push_back(16);
    fd_q.push_back(32);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    do_load(20, 16'h1234, 4'b0000);

    // Frame 2: 1234; load 0050 with dp on digit 2.
    at_cycle(32);
    push_frame(S4, 1'b1, S3, 1'b1, S2, 1'b1, S1, 1'b1);
    fd_q.push_back(48);
    do_load(35, 16'h0050, 4'b0100);

    // Frame 3: 0050 -> digit2 zero-blanked but dp shown; load 9A0F.
    at_cycle(48);
    push_frame(S0, 1'b1, S5, 1'b1, SX, 1'b0, SX, 1'b1);
    fd_q.push_back(64);
    do_load(50, 16'h9A0F, 4'b0000);

    // Frame 4: 9A0F -> invalid codes dark, inner zero shown; load on boundary.
    at_cycle(64);
    push_frame(SX, 1'b1, S0, 1'b1, SX, 1'b1, S9, 1'b1);
    fd_q.push_back(80);
    do_load(79, 16'h5678, 4'b0001);

    // Frame 5: 5678 visible immediately; two loads, the last one wins.
    push_frame(S8, 1'b0, S7, 1'b1, S6, 1'b1, S5, 1'b1);
    fd_q.push_back(96);
    do_load(82, 16'h1111, 4'b0000);
    do_load(86, 16'h2222, 4'b0000);

    // Frame 6: 2222 with blank held over edges 99..108; scan resumes on digit 3.
    at_cycle(96);
    ev_push(4'b1110, S2, 1'b1);
    ev_push(4'b1111, SX, 1'b1);
    ev_push(4'b0111, S2, 1'b1);
    fd_q.push_back(112);
    at_cycle(98);
    blank = 1'b1;
    at_cycle(108);
    blank = 1'b0;

    // Frame 7: pending 0003 then an async reset pulse between edges.
    at_cycle(112);
    ev_push(4'b1110, S2, 1'b1);
    ev_push(4'b1101, S2, 1'b1);
    ev_push(4'b1111, SX, 1'b1);
    push_frame(S0, 1'b1, SX, 1'b1, SX, 1'b1, SX, 1'b1);
    ev_push(4'b1110, S0, 1'b1);
    fd_q.push_back(16);
    do_load(114, 16'h0003, 4'b0000);
    at_cycle(118);
    rst = 1'b1;
    #2;
    rst = 1'b0;

    at_cycle(20);
    @(negedge clk);
    #1;

    total++;
    if (ev_q.size() != 0) begin
      bad++;
      $display("FAIL events_left: got %0d unseen display events want 0", ev_q.size());
    end
    total++;
    if (fd_q.size() != 0) begin
      bad++;
      $display("FAIL frame_done_left: got %0d unseen pulses want 0", fd_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
